gates_reduce_stream: RTL and testbench
======================================

Name: gates_reduce_stream

Overview:
Parametrised streaming reduction unit that extends the 4-bit combinational AND/OR/XOR reducer. It reduces every bit of every beat in a multi-beat frame to single AND, OR and XOR (parity) results, and counts the beats. Input and output use valid/ready handshakes. There is one registered result slot, so the block can sit between stream stages in checker and parity datapaths.

Parameters:
WIDTH, 4, bits per input beat (>=1)
CNT_W, 8, width of the beat counter and out_count (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block accepts the beat this cycle
in_data  input  WIDTH  input beat
in_last  input  1  marks the final beat of a frame
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts the result
out_and  output  1  AND of all bits of all beats in the frame
out_or  output  1  OR of all bits of all beats in the frame
out_xor  output  1  XOR of all bits of all beats in the frame
out_count  output  CNT_W  beats in the frame, saturating
out_sat  output  1  frame had more than 2^CNT_W-1 beats

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk/rst.
- Reset values:
  - out_valid=0; out_and=0, out_or=0, out_xor=0; out_count=0; out_sat=0.
  - Accumulators: acc_and=1, acc_or=0, acc_xor=0, acc_cnt=0, acc_sat=0.
- Reset mid-frame discards the partial frame and any pending result.
- Beat accept: fire_in = in_valid && in_ready.
- in_ready = !out_valid || out_ready. It is combinational and is withheld for every beat, not only last beats, while the result slot is occupied and not draining.
- Non-last beat accepted:
  - acc_and &= &in_data; acc_or |= |in_data; acc_xor ^= ^in_data.
  - acc_cnt increments, saturating at 2^CNT_W-1.
  - acc_sat is set when an increment is attempted at the maximum.
- Last beat accepted:
  - The output registers load the accumulator values combined with this beat.
  - out_count = the saturating increment; out_sat is set under the same rule as acc_sat.
  - out_valid=1 on the next cycle. Latency is 1 cycle from the last-beat accept to the result.
  - Accumulators return to their reset values in the same cycle.
- A single-beat frame (in_last=1 on the first beat) gives out_and=&in_data, out_or=|in_data, out_xor=^in_data, out_count=1.
- Result handshake:
  - out_valid && out_ready clears out_valid on the next cycle.
  - Output data registers keep their old values after the clear; only out_valid is meaningful.
  - While out_valid && !out_ready, all out_* signals are stable.
- Simultaneous result drain and last-beat accept: the new result loads and out_valid stays 1, giving back-to-back frames at 1 result per cycle.
- in_data and in_last are ignored when fire_in=0. The accumulators hold.
- No empty frames exist: every frame contains at least one beat.
- The result slot has no internal state machine beyond out_valid. The accumulators form the implicit frame-in-progress state, which is non-idle when acc_cnt != 0.

Test Plan:
- WIDTH=4, CNT_W=8; single beat 0xF, last=1 -> next cycle out_valid=1, and=1, or=1, xor=0, count=1, sat=0.
- WIDTH=4; frame 0xF, 0xF, 0x7 (last on the third beat), out_ready=1 -> and=0, or=1, xor=1, count=3, exactly one result cycle.
- Backpressure: result pending with out_ready=0 for 5 cycles and next-frame beats offered -> in_ready=0 throughout, outputs stable. Raise out_ready -> the held result drains, then beats are accepted.
- Back-to-back: single-beat frames 0x1, 0x3, 0x0 on consecutive cycles with out_ready=1 -> out_valid held high 3 cycles, xor sequence 1,0,0, and sequence 0,0,0, or sequence 1,1,0.
- Saturation: CNT_W=2; 5-beat frame of 0x8 -> count=3, sat=1, and=0, or=1, xor=1. The next 2-beat frame -> count=2, sat=0.
- Reset mid-frame: beats 0x0, 0x0 (not last), rst for 1 cycle, then single beat 0xF last -> and=1, count=1. Also rst with out_valid=1 -> out_valid=0 the next cycle.

Source files
------------

// File: rtl/gates_reduce_stream.sv
// rtl/gates_reduce_stream.sv - streaming AND/OR/XOR frame reducer with beat count
// Folds every bit of every beat into one result per frame, held in a single valid/ready slot.
module gates_reduce_stream #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_and,
   output logic             out_or,
   output logic             out_xor,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat
);

   logic             fire_in;
   logic             beat_and;
   logic             beat_or;
   logic             beat_xor;
   logic             cnt_max;
   logic [CNT_W-1:0] cnt_nxt;
   logic             sat_nxt;

   logic             acc_and;
   logic             acc_or;
   logic             acc_xor;
   logic [CNT_W-1:0] acc_cnt;
   logic             acc_sat;

   // Ready is withheld for every beat while the slot is full and not draining.
   assign in_ready = !out_valid || out_ready;
   assign fire_in  = in_valid && in_ready;

   assign beat_and = &in_data;
   assign beat_or  = |in_data;
   assign beat_xor = ^in_data;

   assign cnt_max  = (acc_cnt == {CNT_W{1'b1}});
   assign cnt_nxt  = cnt_max ? acc_cnt : acc_cnt + CNT_W'(1);
   assign sat_nxt  = acc_sat || cnt_max;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_and   <= 1'b0;
         out_or    <= 1'b0;
         out_xor   <= 1'b0;
         out_count <= '0;
         out_sat   <= 1'b0;
         acc_and   <= 1'b1;
         acc_or    <= 1'b0;
         acc_xor   <= 1'b0;
         acc_cnt   <= '0;
         acc_sat   <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (fire_in) begin
            if (in_last) begin
               // A last beat that coincides with a drain keeps out_valid high.
               out_valid <= 1'b1;
               out_and   <= acc_and & beat_and;
               out_or    <= acc_or | beat_or;
               out_xor   <= acc_xor ^ beat_xor;
               out_count <= cnt_nxt;
               out_sat   <= sat_nxt;
               acc_and   <= 1'b1;
               acc_or    <= 1'b0;
               acc_xor   <= 1'b0;
               acc_cnt   <= '0;
               acc_sat   <= 1'b0;
            end else begin
               acc_and   <= acc_and & beat_and;
               acc_or    <= acc_or | beat_or;
               acc_xor   <= acc_xor ^ beat_xor;
               acc_cnt   <= cnt_nxt;
               acc_sat   <= sat_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_gates_reduce_stream.sv
// tb/tb_gates_reduce_stream.sv - directed table-driven bench for gates_reduce_stream
// Main instance uses CNT_W=8; a second instance with CNT_W=2 exercises saturation.
module tb_gates_reduce_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic       out_and;
   logic       out_or;
   logic       out_xor;
   logic [7:0] out_count;
   logic       out_sat;

   logic       s_in_valid;
   logic       s_in_ready;
   logic [3:0] s_in_data;
   logic       s_in_last;
   logic       s_out_valid;
   logic       s_out_ready;
   logic       s_out_and;
   logic       s_out_or;
   logic       s_out_xor;
   logic [1:0] s_out_count;
   logic       s_out_sat;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   gates_reduce_stream #(.WIDTH(4), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_and(out_and), .out_or(out_or), .out_xor(out_xor),
      .out_count(out_count), .out_sat(out_sat)
   );

   gates_reduce_stream #(.WIDTH(4), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_and(s_out_and), .out_or(s_out_or), .out_xor(s_out_xor),
      .out_count(s_out_count), .out_sat(s_out_sat)
   );

   typedef struct {
      logic       v;
      logic [3:0] d;
      logic       l;
      logic       ordy;
      logic       e_irdy;
      logic       e_ov;
      logic       e_and;
      logic       e_or;
      logic       e_xor;
      logic [7:0] e_cnt;
      logic       e_sat;
   } vec_t;

   vec_t tbl[$];

   typedef struct {
      int         beats;
      logic [1:0] e_cnt;
      logic       e_sat;
      logic       e_xor;
   } sat_t;

   sat_t sat_tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] d, input logic l, input logic r);
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = r;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      s_in_valid  = 1'b0;
      s_in_data   = 4'h0;
      s_in_last   = 1'b0;
      s_out_ready = 1'b1;

      //         v  d     l  ordy irdy ov and or xor cnt sat
      tbl.push_back('{1, 4'hF, 1, 1, 1, 1, 1, 1, 0, 8'd1, 0});
      tbl.push_back('{0, 4'h0, 0, 1, 1, 0, 1, 1, 0, 8'd1, 0});
      tbl.push_back('{1, 4'hF, 0, 1, 1, 0, 1, 1, 0, 8'd1, 0});
      tbl.push_back('{1, 4'hF, 0, 1, 1, 0, 1, 1, 0, 8'd1, 0});
      tbl.push_back('{1, 4'h7, 1, 1, 1, 1, 0, 1, 1, 8'd3, 0});
      tbl.push_back('{0, 4'h0, 0, 1, 1, 0, 0, 1, 1, 8'd3, 0});
      // backpressure: result held for 5 cycles with beats offered
      tbl.push_back('{1, 4'h1, 1, 0, 1, 1, 0, 1, 1, 8'd1, 0});
      for (int i = 0; i < 5; i++)
         tbl.push_back('{1, 4'hF, 1, 0, 0, 1, 0, 1, 1, 8'd1, 0});
      tbl.push_back('{0, 4'hF, 1, 1, 1, 0, 0, 1, 1, 8'd1, 0});
      tbl.push_back('{1, 4'hF, 1, 1, 1, 1, 1, 1, 0, 8'd1, 0});
      tbl.push_back('{0, 4'h0, 0, 1, 1, 0, 1, 1, 0, 8'd1, 0});
      // back-to-back single-beat frames
      tbl.push_back('{1, 4'h1, 1, 1, 1, 1, 0, 1, 1, 8'd1, 0});
      tbl.push_back('{1, 4'h3, 1, 1, 1, 1, 0, 1, 0, 8'd1, 0});
      tbl.push_back('{1, 4'h0, 1, 1, 1, 1, 0, 0, 0, 8'd1, 0});
      tbl.push_back('{0, 4'h0, 0, 1, 1, 0, 0, 0, 0, 8'd1, 0});
      // data ignored while in_valid is low, including inside a frame
      tbl.push_back('{0, 4'h0, 1, 1, 1, 0, 0, 0, 0, 8'd1, 0});
      tbl.push_back('{1, 4'hA, 1, 1, 1, 1, 0, 1, 0, 8'd1, 0});
      tbl.push_back('{0, 4'h0, 0, 1, 1, 0, 0, 1, 0, 8'd1, 0});
      tbl.push_back('{1, 4'hF, 0, 1, 1, 0, 0, 1, 0, 8'd1, 0});
      tbl.push_back('{0, 4'h0, 1, 1, 1, 0, 0, 1, 0, 8'd1, 0});
      tbl.push_back('{1, 4'hF, 1, 1, 1, 1, 1, 1, 0, 8'd2, 0});
      tbl.push_back('{0, 4'h0, 0, 1, 1, 0, 1, 1, 0, 8'd2, 0});

      sat_tbl.push_back('{5, 2'd3, 1'b1, 1'b1});
      sat_tbl.push_back('{2, 2'd2, 1'b0, 1'b0});
      sat_tbl.push_back('{3, 2'd3, 1'b0, 1'b1});
      sat_tbl.push_back('{4, 2'd3, 1'b1, 1'b0});

      tick();
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("reset out_valid", out_valid, 1'b0);
      chk("reset out_and", out_and, 1'b0);
      chk("reset out_or", out_or, 1'b0);
      chk("reset out_xor", out_xor, 1'b0);
      chk("reset out_count", out_count, 8'd0);
      chk("reset out_sat", out_sat, 1'b0);
      chk("reset in_ready", in_ready, 1'b1);
      chk("reset sat out_valid", s_out_valid, 1'b0);

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy);
         #1;
         chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].e_irdy);
         tick();
         chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].e_ov);
         chk($sformatf("vec%0d out_and", i), out_and, tbl[i].e_and);
         chk($sformatf("vec%0d out_or", i), out_or, tbl[i].e_or);
         chk($sformatf("vec%0d out_xor", i), out_xor, tbl[i].e_xor);
         chk($sformatf("vec%0d out_count", i), out_count, tbl[i].e_cnt);
         chk($sformatf("vec%0d out_sat", i), out_sat, tbl[i].e_sat);
      end

      // reset mid-frame discards the partial zero beats
      drive(1'b1, 4'h0, 1'b0, 1'b1);
      tick();
      tick();
      drive(1'b0, 4'h0, 1'b0, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst out_valid", out_valid, 1'b0);
      drive(1'b1, 4'hF, 1'b1, 1'b1);
      tick();
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      chk("midrst out_valid", out_valid, 1'b1);
      chk("midrst out_and", out_and, 1'b1);
      chk("midrst out_count", out_count, 8'd1);
      // reset while a result is pending
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("pendrst out_valid", out_valid, 1'b0);
      chk("pendrst out_and", out_and, 1'b0);
      chk("pendrst out_count", out_count, 8'd0);

      foreach (sat_tbl[k]) begin
         for (int b = 0; b < sat_tbl[k].beats; b++) begin
            s_in_valid = 1'b1;
            s_in_data  = 4'h8;
            s_in_last  = (b == sat_tbl[k].beats - 1);
            tick();
            if (b < sat_tbl[k].beats - 1)
               chk($sformatf("sat%0d mid out_valid", k), s_out_valid, 1'b0);
         end
         s_in_valid = 1'b0;
         chk($sformatf("sat%0d out_valid", k), s_out_valid, 1'b1);
         chk($sformatf("sat%0d out_count", k), s_out_count, sat_tbl[k].e_cnt);
         chk($sformatf("sat%0d out_sat", k), s_out_sat, sat_tbl[k].e_sat);
         chk($sformatf("sat%0d out_and", k), s_out_and, 1'b0);
         chk($sformatf("sat%0d out_or", k), s_out_or, 1'b1);
         chk($sformatf("sat%0d out_xor", k), s_out_xor, sat_tbl[k].e_xor);
         tick();
         chk($sformatf("sat%0d drained", k), s_out_valid, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
